// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I datapath: sequences fetch/decode/
// execute/memory/writeback, drives datapath strobes and counts retired instructions.
module rv_multicycle_ctrl #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [31:0]          i_inst,
  input  logic                 i_imem_ready,
  input  logic                 i_dmem_ready,
  input  logic                 i_branch_taken,
  output logic [5:0]           o_format,
  output logic                 o_imem_req,
  output logic                 o_ir_write,
  output logic                 o_dmem_req,
  output logic                 o_dmem_wen,
  output logic                 o_rf_wen,
  output logic [1:0]           o_wb_sel,
  output logic                 o_pc_write,
  output logic [1:0]           o_pc_sel,
  output logic [2:0]           o_state,
  output logic                 o_retire,
  output logic                 o_halt,
  output logic                 o_illegal,
  output logic [CNT_WIDTH-1:0] o_retired
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic                 halt_q, halt_d;
  logic                 illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0] retired_q;

  logic [6:0] opcode;
  logic [5:0] fmt_c;
  logic       rd_nz;
  logic       unused_inst;

  logic       imem_req_c, ir_write_c, dmem_req_c, dmem_wen_c;
  logic       rf_wen_c, pc_write_c, retire_c;
  logic [1:0] wb_sel_c, pc_sel_c;

  assign opcode      = i_inst[6:0];
  assign rd_nz       = (i_inst[11:7] != 5'd0);
  assign unused_inst = ^i_inst[31:12];

  // One-hot format for the immediate generator; all-zero marks an illegal opcode
  always_comb begin
    fmt_c = 6'b000000;
    case (opcode)
      OPC_OP:                                               fmt_c = 6'b000001;
      OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_FENCE, OPC_SYSTEM: fmt_c = 6'b000010;
      OPC_STORE:                                            fmt_c = 6'b000100;
      OPC_BRANCH:                                           fmt_c = 6'b001000;
      OPC_LUI, OPC_AUIPC:                                   fmt_c = 6'b010000;
      OPC_JAL:                                              fmt_c = 6'b100000;
      default:                                              fmt_c = 6'b000000;
    endcase
  end

  // Next-state and strobe decode
  always_comb begin
    state_d    = state_q;
    halt_d     = halt_q;
    illegal_d  = illegal_q;
    imem_req_c = 1'b0;
    ir_write_c = 1'b0;
    dmem_req_c = 1'b0;
    dmem_wen_c = 1'b0;
    rf_wen_c   = 1'b0;
    wb_sel_c   = 2'b00;
    pc_write_c = 1'b0;
    pc_sel_c   = 2'b00;
    retire_c   = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (i_imem_ready) begin
          ir_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        if (fmt_c == 6'b000000) begin
          state_d   = S_HALT;
          halt_d    = 1'b1;
          illegal_d = 1'b1;
        end else if (opcode == OPC_SYSTEM) begin
          state_d = S_HALT;
          halt_d  = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (opcode == OPC_BRANCH || opcode == OPC_FENCE) begin
          pc_write_c = 1'b1;
          pc_sel_c   = (opcode == OPC_BRANCH && i_branch_taken) ? 2'b01 : 2'b00;
          retire_c   = 1'b1;
          state_d    = S_FETCH;
        end else if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_wen_c = (opcode == OPC_STORE);
        if (i_dmem_ready) begin
          if (opcode == OPC_STORE) begin
            pc_write_c = 1'b1;
            retire_c   = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_wen_c   = rd_nz;
        pc_write_c = 1'b1;
        retire_c   = 1'b1;
        state_d    = S_FETCH;
        case (opcode)
          OPC_LOAD: wb_sel_c = 2'b01;
          OPC_JAL:  begin wb_sel_c = 2'b10; pc_sel_c = 2'b01; end
          OPC_JALR: begin wb_sel_c = 2'b10; pc_sel_c = 2'b10; end
          OPC_LUI:  wb_sel_c = 2'b11;
          default:  wb_sel_c = 2'b00;
        endcase
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_FETCH;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      halt_q    <= halt_d;
      illegal_q <= illegal_d;
      if (retire_c) retired_q <= retired_q + CNT_WIDTH'(1);
    end
  end

  // Reset masks every strobe, including one raised by a pending memory wait
  assign o_imem_req = imem_req_c & ~i_rst;
  assign o_ir_write = ir_write_c & ~i_rst;
  assign o_dmem_req = dmem_req_c & ~i_rst;
  assign o_dmem_wen = dmem_wen_c & ~i_rst;
  assign o_rf_wen   = rf_wen_c   & ~i_rst;
  assign o_pc_write = pc_write_c & ~i_rst;
  assign o_retire   = retire_c   & ~i_rst;
  assign o_wb_sel   = wb_sel_c;
  assign o_pc_sel   = pc_sel_c;
  assign o_format   = fmt_c;
  assign o_state    = 3'(state_q);
  assign o_halt     = halt_q;
  assign o_illegal  = illegal_q;
  assign o_retired  = retired_q;

endmodule
